// File: rtl/run_controller.sv
// Load/run sequencer for a small datapath: streams a program into instruction memory, then
// starts, stops, resumes and watchdogs execution from debounced button edges.
module run_controller #(
   parameter int unsigned DW      = 16,
   parameter int unsigned AW      = 8,
   parameter int unsigned MAX_CYC = 65535
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_valid,
   input  logic [DW-1:0] ld_data,
   input  logic          ld_last,
   output logic          ld_ready,
   input  logic          btn_run,
   input  logic          btn_stop,
   input  logic          btn_clear,
   input  logic          halt,
   output logic [DW-1:0] user_inst_write,
   output logic [AW-1:0] user_inst_addr,
   output logic          user_inst_wen,
   output logic          ap_start,
   output logic          ap_stop,
   output logic          resume,
   output logic          dp_rst,
   output logic [2:0]    state,
   output logic [AW:0]   prog_len,
   output logic          timeout,
   output logic          ovf
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StLoad   = 3'd1,
      StReady  = 3'd2,
      StStart  = 3'd3,
      StRun    = 3'd4,
      StHalted = 3'd5,
      StResume = 3'd6,
      StDone   = 3'd7
   } state_e;

   localparam logic [AW-1:0] AddrOne = 1;
   localparam logic [AW:0]   LenOne  = 1;
   localparam logic [31:0]   MaxCyc  = 32'(MAX_CYC);

   state_e        state_q, state_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [AW:0]   prog_len_q, prog_len_d;
   logic          ovf_q, ovf_d, timeout_q, timeout_d;
   logic [31:0]   cyc_q, cyc_d;
   logic          res_cnt_q, res_cnt_d;
   logic          run_prev_q, stop_prev_q, clear_prev_q;
   logic          run_edge, stop_edge, clear_edge, accept;
   logic          ld_ready_q, ld_ready_d, wen_q, wen_d;
   logic [DW-1:0] write_q, write_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic          ap_start_q, ap_start_d, ap_stop_q, ap_stop_d;
   logic          resume_q, resume_d, dp_rst_q, dp_rst_d;

   assign run_edge   = btn_run & ~run_prev_q;
   assign stop_edge  = btn_stop & ~stop_prev_q;
   assign clear_edge = btn_clear & ~clear_prev_q;
   // ld_ready_q is high exactly in IDLE and LOAD, so it doubles as the accept gate
   assign accept     = ld_valid & ld_ready_q;

   always_comb begin
      state_d    = state_q;
      wr_addr_d  = wr_addr_q;
      prog_len_d = prog_len_q;
      ovf_d      = ovf_q;
      timeout_d  = timeout_q;
      cyc_d      = cyc_q;
      res_cnt_d  = res_cnt_q;
      wen_d      = 1'b0;
      write_d    = write_q;
      waddr_d    = waddr_q;
      ap_start_d = 1'b0;
      ap_stop_d  = 1'b0;
      resume_d   = 1'b0;
      dp_rst_d   = 1'b0;

      if (clear_edge && state_q != StStart && state_q != StResume) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  wen_d      = 1'b1;
                  write_d    = ld_data;
                  waddr_d    = '0;
                  wr_addr_d  = AddrOne;
                  prog_len_d = LenOne;
                  ovf_d      = 1'b0;
                  state_d    = ld_last ? StReady : StLoad;
               end
            end
            StLoad: begin
               if (accept) begin
                  wen_d      = 1'b1;
                  write_d    = ld_data;
                  waddr_d    = wr_addr_q;
                  prog_len_d = prog_len_q + LenOne;
                  if (wr_addr_q != '1) wr_addr_d = wr_addr_q + AddrOne;
                  if (ld_last) begin
                     state_d = StReady;
                  end else if (wr_addr_q == '1) begin
                     ovf_d   = 1'b1;
                     state_d = StReady;
                  end
               end
            end
            StReady, StDone: begin
               if (run_edge) state_d = StStart;
            end
            StStart: begin
               state_d    = StRun;
               cyc_d      = '0;
               ap_start_d = 1'b1;
            end
            StRun: begin
               if (stop_edge) begin
                  ap_stop_d = 1'b1;
                  state_d   = StDone;
               end else if (halt) begin
                  state_d = StHalted;
               end else if (cyc_q == MaxCyc) begin
                  ap_stop_d = 1'b1;
                  timeout_d = 1'b1;
                  state_d   = StDone;
               end else begin
                  cyc_d = cyc_q + 32'd1;
               end
            end
            StHalted: begin
               if (stop_edge) begin
                  ap_stop_d = 1'b1;
                  state_d   = StDone;
               end else if (run_edge) begin
                  resume_d  = 1'b1;
                  res_cnt_d = 1'b0;
                  state_d   = StResume;
               end
            end
            StResume: begin
               // two cycles with halt masked while the datapath clears its halt flag
               if (res_cnt_q) state_d = StRun;
               else res_cnt_d = 1'b1;
            end
            default: state_d = StIdle;
         endcase
      end

      if (state_d == StStart && state_q != StStart) begin
         dp_rst_d  = 1'b1;
         timeout_d = 1'b0;
      end
      ld_ready_d = (state_d == StIdle) || (state_d == StLoad);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         wr_addr_q    <= '0;
         prog_len_q   <= '0;
         ovf_q        <= 1'b0;
         timeout_q    <= 1'b0;
         cyc_q        <= '0;
         res_cnt_q    <= 1'b0;
         run_prev_q   <= 1'b0;
         stop_prev_q  <= 1'b0;
         clear_prev_q <= 1'b0;
         ld_ready_q   <= 1'b1;
         wen_q        <= 1'b0;
         write_q      <= '0;
         waddr_q      <= '0;
         ap_start_q   <= 1'b0;
         ap_stop_q    <= 1'b0;
         resume_q     <= 1'b0;
         dp_rst_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_addr_q    <= wr_addr_d;
         prog_len_q   <= prog_len_d;
         ovf_q        <= ovf_d;
         timeout_q    <= timeout_d;
         cyc_q        <= cyc_d;
         res_cnt_q    <= res_cnt_d;
         run_prev_q   <= btn_run;
         stop_prev_q  <= btn_stop;
         clear_prev_q <= btn_clear;
         ld_ready_q   <= ld_ready_d;
         wen_q        <= wen_d;
         write_q      <= write_d;
         waddr_q      <= waddr_d;
         ap_start_q   <= ap_start_d;
         ap_stop_q    <= ap_stop_d;
         resume_q     <= resume_d;
         dp_rst_q     <= dp_rst_d;
      end
   end

   assign state           = state_q;
   assign ld_ready        = ld_ready_q;
   assign user_inst_wen   = wen_q;
   assign user_inst_write = write_q;
   assign user_inst_addr  = waddr_q;
   assign ap_start        = ap_start_q;
   assign ap_stop         = ap_stop_q;
   assign resume          = resume_q;
   assign dp_rst          = dp_rst_q;
   assign prog_len        = prog_len_q;
   assign timeout         = timeout_q;
   assign ovf             = ovf_q;

endmodule
